// File: rtl/qq_level_fetch.sv
// qq_level_fetch
//   Front stage of one QuickQ level. Takes a single enqueue/dequeue op,
//   reads the addressed RAM word through a 1-cycle synchronous RAM port,
//   and presents {top-of-queue register, RAM word, op} to the value router.
//   It then waits for the router's feedback, which updates the top register,
//   optionally writes a word back to RAM, and updates occupancy.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   op_valid/op_ready             op request handshake (op_type, op_data, op_addr)
//   ram_rd_en/addr, ram_rd_data   synchronous RAM read port (data one cycle later)
//   ram_wr_en/addr/data           RAM write port (write-back from the router)
//   out_valid/out_ready           router operands handshake
//   reg_data, ram_data            top-of-queue register, captured RAM word
//   out_type, out_new             latched op type and op data
//   fb_valid, fb_reg, fb_ram_we,  router feedback, consumed only in WB
//   fb_ram
//   count, full, empty            occupancy
//   err                           one-cycle pulse after an illegal op is accepted
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. valid, once raised, stays high with its payload stable until
// that edge; ready may change freely.
//
// Build option
//   QQ_EMPTY_BYPASS_EN: a legal enqueue into an empty level skips the RAM
//   read (nothing useful is stored there) and presents the all-ones sentinel
//   as the RAM word, cutting latency from 3 cycles to 1.

module qq_level_fetch #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic              op_type,
  input  logic [DATA_W-1:0] op_data,
  input  logic [ADDR_W-1:0] op_addr,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] reg_data,
  output logic [DATA_W-1:0] ram_data,
  output logic              out_type,
  output logic [DATA_W-1:0] out_new,
  input  logic              fb_valid,
  input  logic [DATA_W-1:0] fb_reg,
  input  logic              fb_ram_we,
  input  logic [DATA_W-1:0] fb_ram,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              err
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_WAIT    = 3'd2,
    S_PRESENT = 3'd3,
    S_WB      = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] top_q;
  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] new_q;
  logic              type_q;
  logic [ADDR_W:0]   count_q;
  logic              err_q;

  logic accept;
  logic illegal;
  logic bypass;
  logic fb_take;

  assign accept  = op_valid & op_ready;
  // Dequeue needs something to remove, enqueue needs a free slot.
  assign illegal = op_type ? empty : full;
  assign fb_take = fb_valid & (state_q == S_WB);

`ifdef QQ_EMPTY_BYPASS_EN
  assign bypass = ~op_type & empty;
`else
  assign bypass = 1'b0;
`endif

  // ---------------- state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept && !illegal) state_d = bypass ? S_PRESENT : S_READ;
      end
      S_READ:    state_d = S_WAIT;
      S_WAIT:    state_d = S_PRESENT;
      S_PRESENT: if (out_ready) state_d = S_WB;
      S_WB:      if (fb_valid) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // ---------------- outputs ----------------
  always_comb begin
    op_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_PRESENT);
    ram_rd_en = (state_q == S_READ);
    ram_wr_en = fb_take & fb_ram_we;
  end

  assign ram_rd_addr = addr_q;
  assign ram_wr_addr = addr_q;
  assign ram_wr_data = fb_ram;
  assign reg_data    = top_q;
  assign ram_data    = ram_q;
  assign out_type    = type_q;
  assign out_new     = new_q;
  assign count       = count_q;
  assign full        = (count_q == DEPTH_C);
  assign empty       = (count_q == '0);
  assign err         = err_q;

  // ---------------- datapath ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      type_q  <= 1'b0;
      new_q   <= '0;
      ram_q   <= '0;
      top_q   <= '1;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= accept & illegal;
      if (accept) begin
        addr_q <= op_addr;
        type_q <= op_type;
        new_q  <= op_data;
        // Empty level: the sentinel stands in for the unread RAM word.
        if (!illegal && bypass) ram_q <= '1;
      end
      if (state_q == S_WAIT) ram_q <= ram_rd_data;
      if (fb_take) begin
        top_q <= fb_reg;
        // Range is guaranteed by the illegal-op check, so no saturation.
        if (type_q) count_q <= count_q - 1'b1;
        else        count_q <= count_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_qq_level_fetch.sv
module tb_qq_level_fetch;

  localparam int DW = 16;
  localparam int DEPTH = 16;
  localparam int AW = 4;
  localparam logic [DW-1:0] SENT = 16'hFFFF;
`ifdef QQ_EMPTY_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          op_valid = 0, op_type = 0, out_ready = 0;
  logic [DW-1:0] op_data = '0;
  logic [AW-1:0] op_addr = '0;
  logic          fb_valid = 0, fb_ram_we = 0;
  logic [DW-1:0] fb_reg = '0, fb_ram = '0;
  logic          op_ready, ram_rd_en, ram_wr_en, out_valid, out_type, full, empty, err;
  logic [AW-1:0] ram_rd_addr, ram_wr_addr;
  logic [DW-1:0] ram_rd_data = '0, ram_wr_data, reg_data, ram_data, out_new;
  logic [AW:0]   count;

  qq_level_fetch #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .op_valid(op_valid), .op_ready(op_ready), .op_type(op_type),
    .op_data(op_data), .op_addr(op_addr),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .reg_data(reg_data), .ram_data(ram_data), .out_type(out_type), .out_new(out_new),
    .fb_valid(fb_valid), .fb_reg(fb_reg), .fb_ram_we(fb_ram_we), .fb_ram(fb_ram),
    .count(count), .full(full), .empty(empty), .err(err)
  );

  // Synchronous RAM the level talks to.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
  end

  // ---------------- reference model ----------------
  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] model_top = SENT;
  int            model_count = 0;

  typedef struct packed {
    logic          is_err;
    logic          typ;
    logic [DW-1:0] nw;
    logic [DW-1:0] rg;
    logic [DW-1:0] rm;
  } exp_t;
  exp_t          exp_q[$];
  logic [AW+DW-1:0] wr_q[$];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (err) begin
        if (exp_q.size() == 0) chk("err_unexpected", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("err_expected", 32'(e.is_err), 32'd1);
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("present_unexpected", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("present_kind", 32'(e.is_err), 32'd0);
          chk("out_type", 32'(out_type), 32'(e.typ));
          chk("out_new", 32'(out_new), 32'(e.nw));
          chk("reg_data", 32'(reg_data), 32'(e.rg));
          chk("ram_data", 32'(ram_data), 32'(e.rm));
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [AW+DW-1:0] w;
    if (!rst && ram_wr_en) begin
      if (wr_q.size() == 0) chk("wr_unexpected", 32'd1, 32'd0);
      else begin
        w = wr_q.pop_front();
        chk("wr_addr", 32'(ram_wr_addr), 32'(w[AW+DW-1:DW]));
        chk("wr_data", 32'(ram_wr_data), 32'(w[DW-1:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_count"}, 32'(count), 32'(model_count));
    chk({tag, "_full"}, 32'(full), 32'(model_count == DEPTH));
    chk({tag, "_empty"}, 32'(empty), 32'(model_count == 0));
    chk({tag, "_reg"}, 32'(reg_data), 32'(model_top));
    chk({tag, "_op_ready"}, 32'(op_ready), 32'd1);
    chk({tag, "_drained"}, 32'(exp_q.size() + wr_q.size()), 32'd0);
  endtask

  // One complete op, playing both the requester and the router.
  task automatic do_op(input logic typ, input logic [DW-1:0] data, input logic [AW-1:0] addr,
                       input int bp, input logic [DW-1:0] f_reg, input logic f_we,
                       input logic [DW-1:0] f_ram, input int wb_dly);
    bit legal, byp;
    int lat, reads;
    logic [DW-1:0] exp_ram;
    exp_t e;
    legal = typ ? (model_count > 0) : (model_count < DEPTH);
    byp   = BYPASS && !typ && model_count == 0;
    chk("op_ready_before", 32'(op_ready), 32'd1);
    op_valid = 1; op_type = typ; op_data = data; op_addr = addr;
    if (!legal) begin
      e = '{is_err: 1'b1, typ: typ, nw: data, rg: '0, rm: '0};
      exp_q.push_back(e);
      step();
      op_valid = 0;
      repeat (3) begin
        @(negedge clk);
        chk("illegal_no_rd", 32'(ram_rd_en), 32'd0);
        chk("illegal_op_ready", 32'(op_ready), 32'd1);
        chk("illegal_no_out", 32'(out_valid), 32'd0);
      end
      step();
      check_state("illegal");
      return;
    end
    exp_ram = byp ? SENT : model_mem[addr];
    e = '{is_err: 1'b0, typ: typ, nw: data, rg: model_top, rm: exp_ram};
    exp_q.push_back(e);
    step();                       // accept edge
    op_valid = 0;
    lat = 1; reads = 0;
    while (!out_valid && lat < 20) begin
      if (ram_rd_en) begin
        reads++;
        chk("rd_addr", 32'(ram_rd_addr), 32'(addr));
      end
      step();
      lat++;
    end
    chk("latency", 32'(lat), byp ? 32'd1 : 32'd3);
    chk("rd_count", 32'(reads), byp ? 32'd0 : 32'd1);
    if (!out_valid) return;
    // Backpressure, with stray feedback that must be ignored.
    for (int i = 0; i < bp; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        fb_valid = 1; fb_ram_we = 1; fb_reg = 16'($urandom); fb_ram = 16'($urandom);
      end
      @(negedge clk);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_op_ready", 32'(op_ready), 32'd0);
      chk("bp_reg", 32'(reg_data), 32'(e.rg));
      chk("bp_ram", 32'(ram_data), 32'(e.rm));
      chk("bp_new", 32'(out_new), 32'(e.nw));
      chk("bp_type", 32'(out_type), 32'(e.typ));
      step();
      fb_valid = 0; fb_ram_we = 0;
    end
    out_ready = 1;
    step();
    out_ready = 0;
    chk("valid_drop", 32'(out_valid), 32'd0);
    repeat (wb_dly) step();
    chk("wb_hold", 32'(op_ready), 32'd0);
    fb_valid = 1; fb_reg = f_reg; fb_ram_we = f_we; fb_ram = f_ram;
    if (f_we) wr_q.push_back({addr, f_ram});
    step();
    fb_valid = 0; fb_ram_we = 0;
    model_top = f_reg;
    if (f_we) model_mem[addr] = f_ram;
    model_count = typ ? model_count - 1 : model_count + 1;
    check_state("op");
  endtask

  task automatic rand_op(input bit force_enq);
    logic typ;
    typ = force_enq ? 1'b0 : 1'($urandom_range(0, 1));
    do_op(typ, 16'($urandom), 4'($urandom_range(0, 15)), $urandom_range(0, 3),
          16'($urandom), 1'($urandom_range(0, 1)), 16'($urandom), $urandom_range(0, 3));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = 16'($urandom);
      model_mem[i] = mem[i];
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_rd_en", 32'(ram_rd_en), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ram_data", 32'(ram_data), 32'd0);
    chk("rst_out_new", 32'(out_new), 32'd0);
    chk("rst_out_type", 32'(out_type), 32'd0);
    rst = 0;
    step();
    check_state("reset");

    // Dequeue on empty.
    do_op(1'b1, 16'h1234, 4'd5, 0, 16'h0, 1'b0, 16'h0, 0);
    // Enqueue 0x0010 to addr 3 into empty level.
    do_op(1'b0, 16'h0010, 4'd3, 0, 16'h0010, 1'b1, 16'hFFFF, 0);
    chk("dir_mem3", 32'(mem[3]), 32'hFFFF);
    // Second enqueue with count = 1 (always takes the RAM path).
    do_op(1'b0, 16'h0020, 4'd7, 0, 16'h0010, 1'b1, 16'h0020, 1);
    do_op(1'b1, 16'h0, 4'd7, 0, 16'h0020, 1'b0, 16'h0, 0);
    do_op(1'b1, 16'h0, 4'd3, 0, SENT, 1'b1, SENT, 2);

    // Fill to full, then overflow.
    for (int i = 0; i < DEPTH; i++) rand_op(1'b1);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd16);
    do_op(1'b0, 16'h0BAD, 4'd1, 0, 16'h0, 1'b0, 16'h0, 0);
    chk("overflow_count", 32'(count), 32'd16);

    // Five cycles of backpressure.
    do_op(1'b1, 16'h0, 4'd9, 5, 16'h0042, 1'b1, 16'h0077, 0);

    // Random mix.
    for (int i = 0; i < 150; i++) rand_op(1'b0);

    // Reset while presenting.
    op_valid = 1; op_type = (model_count < DEPTH) ? 1'b0 : 1'b1;
    op_data = 16'h5555; op_addr = 4'd2;
    step();
    op_valid = 0;
    for (int i = 0; i < 10 && !out_valid; i++) step();
    chk("midop_present", 32'(out_valid), 32'd1);
    rst = 1;
    #2;
    chk("midop_out_valid", 32'(out_valid), 32'd0);
    chk("midop_reg", 32'(reg_data), 32'(SENT));
    chk("midop_count", 32'(count), 32'd0);
    chk("midop_op_ready", 32'(op_ready), 32'd1);
    exp_q.delete();
    model_count = 0;
    model_top = SENT;
    step();
    rst = 0;
    fb_valid = 1; fb_ram_we = 1; fb_reg = 16'h1111; fb_ram = 16'h2222;
    repeat (2) begin
      @(negedge clk);
      chk("midop_no_wr", 32'(ram_wr_en), 32'd0);
    end
    step();
    fb_valid = 0; fb_ram_we = 0;
    check_state("after_rst");
    for (int i = 0; i < 10; i++) rand_op(1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    fails++;
    $display("FAIL watchdog: simulation did not complete, expected finish before timeout");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
